median_filter_sequencer: RTL and testbench



---
 rtl/medseq_pkg.sv | 25 ++
 rtl/median_filter_sequencer_stage.sv | 18 +
 rtl/median_filter_sequencer.sv | 102 ++++++++++
 tb/tb_median_filter_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/medseq_pkg.sv
// Shared types and constants for the median filter sequencer.
// MEDSEQ_EARLY_EXIT_EN enables stopping early once the filter reaches a fixed point.
package medseq_pkg;

  localparam int DATA_W = 6;
  localparam int PASS_W = 3;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/median_filter_sequencer_stage.sv
// Combinational 3-tap bitwise median over a 6-bit word.
// Bit 5 of the input never reaches the output.
module bit_median_stage
  import medseq_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  // bit 5 is deliberately dropped
  assign y[5] = 1'b0 & x[5];
  assign y[4] = x[4] & x[3];
  assign y[3] = maj3(x[4], x[3], x[2]);
  assign y[2] = maj3(x[3], x[2], x[1]);
  assign y[1] = maj3(x[2], x[1], x[0]);
  assign y[0] = x[1] & x[0];

endmodule

// File: rtl/median_filter_sequencer.sv
// Two-requester round-robin scheduler around one iterated median stage.
// MEDSEQ_EARLY_EXIT_EN: finish a job as soon as a pass leaves work unchanged.
module median_filter_sequencer
  import medseq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_operand,
  input  logic [PASS_W-1:0] req0_passes,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_operand,
  input  logic [PASS_W-1:0] req1_passes,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic              out_src,
  output logic [PASS_W-1:0] out_passes_done
);

  state_t state, state_n;

  logic [DATA_W-1:0] work, work_f, sel_op;
  logic [PASS_W-1:0] target, count, cnt_inc;
  logic [PASS_W-1:0] sel_passes;
  logic src, last_grant, grant;
  logic accept, last_pass;

  bit_median_stage u_stage (
    .x (work),
    .y (work_f)
  );

  always_comb begin
    grant = REQ0;
    unique case (1'b1)
      req0_valid & req1_valid:  grant = ~last_grant;
      ~req0_valid & req1_valid: grant = REQ1;
      default:                  grant = REQ0;
    endcase
  end

  assign accept = ~reset & (state == IDLE)
                & (req0_valid | req1_valid);

  assign req0_ready = accept & (grant == REQ0);
  assign req1_ready = accept & (grant == REQ1);

  assign sel_op     = grant ? req1_operand : req0_operand;
  assign sel_passes = grant ? req1_passes : req0_passes;

  assign cnt_inc = count + PASS_W'(1);

`ifdef MEDSEQ_EARLY_EXIT_EN
  assign last_pass = (cnt_inc == target) | (work_f == work);
`else
  assign last_pass = (cnt_inc == target);
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept)
              state_n = (sel_passes != '0) ? RUN : DONE;
      RUN:  if (last_pass) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work       <= '0;
      target     <= '0;
      count      <= '0;
      src        <= REQ0;
      last_grant <= REQ1;
    end else if (accept) begin
      work       <= sel_op;
      target     <= sel_passes;
      count      <= '0;
      src        <= grant;
      last_grant <= grant;
    end else if (state == RUN) begin
      work  <= work_f;
      count <= cnt_inc;
    end
  end

  assign out_valid       = (state == DONE);
  assign out_value       = work;
  assign out_src         = src;
  assign out_passes_done = count;

endmodule

// File: tb/tb_median_filter_sequencer.sv
// Self-checking bench for median_filter_sequencer.
// Honours MEDSEQ_EARLY_EXIT_EN in its reference model.
module tb_median_filter_sequencer;

`ifdef MEDSEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [5:0] req0_operand, req1_operand;
  logic [2:0] req0_passes, req1_passes;
  logic       req0_ready, req1_ready;
  logic       out_valid, out_ready;
  logic [5:0] out_value;
  logic       out_src;
  logic [2:0] out_passes_done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  median_filter_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_operand    (req0_operand),
    .req0_passes     (req0_passes),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_operand    (req1_operand),
    .req1_passes     (req1_passes),
    .req1_ready      (req1_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_value       (out_value),
    .out_src         (out_src),
    .out_passes_done (out_passes_done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // median of the left neighbour, self and right neighbour, bit 5 forced to 0
  function automatic logic [5:0] ref_f(input logic [5:0] x);
    logic [5:0] y, l, r;
    y = {1'b0, x[4:0]};
    l = y << 1;
    r = y >> 1;
    return (l & y) | (l & r) | (y & r);
  endfunction

  function automatic logic [8:0] ref_job(input logic [5:0] op,
                                         input int p);
    logic [5:0] v, nv;
    int n;
    v = op;
    n = 0;
    for (int k = 0; k < p; k++) begin
      nv = ref_f(v);
      n++;
      if (EARLY && nv == v) break;
      v = nv;
    end
    return {n[2:0], v};
  endfunction

  task automatic run_job(input  logic       s,
                         input  logic [5:0] op,
                         input  logic [2:0] p,
                         input  int         hold,
                         output logic [5:0] ov,
                         output logic [2:0] od,
                         output int         lat);
    logic [8:0] m;
    logic [5:0] cv;
    logic       cs;
    logic [2:0] cd;
    m = ref_job(op, int'(p));
    out_ready = (hold == 0);
    @(negedge clk);
    req0_valid   = (s == 1'b0);
    req1_valid   = (s == 1'b1);
    req0_operand = op;
    req1_operand = op;
    req0_passes  = p;
    req1_passes  = p;
    #1;
    check("accept_ready", s ? req1_ready : req0_ready, 1);
    check("idle_other_ready", s ? req0_ready : req1_ready, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ov = out_value;
    od = out_passes_done;
    check("latency", lat, int'(m[8:6]));
    check("value", out_value, m[5:0]);
    check("src", out_src, s);
    check("passes_done", out_passes_done, m[8:6]);
    cv = out_value;
    cs = out_src;
    cd = out_passes_done;
    for (int h = 0; h < hold; h++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_value", out_value, cv);
      check("hold_src", out_src, cs);
      check("hold_passes", out_passes_done, cd);
      check("hold_readies", {req0_ready, req1_ready}, 2'b00);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", out_valid, 0);
  endtask

  logic [5:0] ov, op0, op1, last_op;
  logic [2:0] od;
  int         lat, nacc;
  logic       exp_g, last_src;

  initial begin
    reset        = 1'b1;
    out_ready    = 1'b1;
    req0_valid   = 1'b1;
    req1_valid   = 1'b1;
    req0_operand = 6'h3f;
    req1_operand = 6'h15;
    req0_passes  = 3'd0;
    req1_passes  = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readies", {req0_ready, req1_ready}, 2'b00);
    check("rst_valid", out_valid, 0);
    check("rst_value", out_value, 0);
    check("rst_src", out_src, 0);
    check("rst_passes", out_passes_done, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset      = 1'b0;

    run_job(1'b0, 6'b101010, 3'd1, 0, ov, od, lat);
    check("d1_value", ov, 6'b000100);
    check("d1_lat", lat, 1);

    run_job(1'b1, 6'b011010, 3'd3, 0, ov, od, lat);
    check("d2_value", ov, 6'b011100);
    check("d2_passes", od, EARLY ? 3'd2 : 3'd3);

    run_job(1'b0, 6'($urandom), 3'd2, 5, ov, od, lat);

    for (int j = 0; j < 12; j++)
      run_job(1'($urandom), 6'($urandom),
              3'($urandom_range(0, 7)), 0, ov, od, lat);

    @(negedge clk);
    req0_valid   = 1'b1;
    req0_operand = 6'($urandom);
    req0_passes  = 3'd7;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_passes", out_passes_done, 0);

    exp_g    = 1'b0;
    nacc     = 0;
    last_op  = '0;
    last_src = 1'b0;
    req0_passes = 3'd0;
    req1_passes = 3'd0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      op0 = 6'($urandom);
      op1 = 6'($urandom);
      req0_operand = op0;
      req1_operand = op1;
      req0_valid   = 1'b1;
      req1_valid   = 1'b1;
      #1;
      if (out_valid) begin
        check("alt_value", out_value, last_op);
        check("alt_src", out_src, last_src);
      end
      check("alt_one_ready", req0_ready & req1_ready, 0);
      if (req0_ready | req1_ready) begin
        check("alt_grant", req1_ready, exp_g);
        last_op  = exp_g ? op1 : op0;
        last_src = exp_g;
        exp_g    = ~exp_g;
        nacc++;
      end
    end
    check("alt_count", nacc, 8);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
